// File: rtl/mcycle_sequencer_pkg.sv
// Shared core definitions for the M-cycle/T-cycle sequencer.
// Holds the sequencer states, data-bus source selects and register codes.
package mcycle_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_RUN,
        ST_WAIT,
        ST_HALT
    } seq_state_e;

    typedef enum logic [1:0] {
        DBUS_SBUS,
        DBUS_ALU,
        DBUS_MEM,
        DBUS_DEBUG
    } dbus_sel_e;

    localparam logic [2:0] REG_B  = 3'd0;
    localparam logic [2:0] REG_C  = 3'd1;
    localparam logic [2:0] REG_D  = 3'd2;
    localparam logic [2:0] REG_E  = 3'd3;
    localparam logic [2:0] REG_H  = 3'd4;
    localparam logic [2:0] REG_L  = 3'd5;
    localparam logic [2:0] REG_HL = 3'd6;
    localparam logic [2:0] REG_A  = 3'd7;

    // Decoder M-cycle count clamped to 1..maxv.
    function automatic int sat_count(input int v, input int maxv);
        if (v < 1) return 1;
        if (v > maxv) return maxv;
        return v;
    endfunction

endpackage

// File: rtl/mcycle_wait_ctr.sv
// Memory wait-state counter; flags the final permitted wait clock.
module mcycle_wait_ctr
    import mcycle_sequencer_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    output logic timeout_o
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    always_comb begin
        cnt_d = '0;
        if (inc_i) begin
            if (cnt_q != CW'(WAIT_MAX)) cnt_d = cnt_q + 1'b1;
            else                        cnt_d = cnt_q;
        end
    end

    assign timeout_o = (cnt_q >= CW'(WAIT_MAX - 1));

endmodule

// File: rtl/mcycle_sequencer.sv
// M-cycle/T-cycle timing sequencer: cycle position, memory strobes,
// wait states with timeout, opcode-fetch overlap and HALT/wake.
module mcycle_sequencer
    import mcycle_sequencer_pkg::*;
#(
    parameter int T_PER_M  = 4,
    parameter int MAX_M    = 6,
    parameter int WAIT_MAX = 15,
    parameter int TW       = $clog2(T_PER_M),
    parameter int MW       = $clog2(MAX_M + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [MW-1:0] m_count,
    input  logic          mem_req_rd,
    input  logic          mem_req_wr,
    input  logic          mem_ready,
    input  logic          halt_req,
    input  logic          wake,
    output logic [MW-1:0] m_cycle,
    output logic [TW-1:0] t_cycle,
    output logic          m1t1,
    output logic          last_m,
    output logic          writeback,
    output logic          rd,
    output logic          wr,
    output logic          fetch_en,
    output logic          stall,
    output logic          halted,
    output logic          bus_err
);

    localparam logic [TW-1:0] T_STB  = TW'(T_PER_M - 2);
    localparam logic [TW-1:0] T_LAST = TW'(T_PER_M - 1);

    seq_state_e    state_q, state_d;
    logic [MW-1:0] m_q, m_d;
    logic [TW-1:0] t_q, t_d;
    logic [MW-1:0] mcnt_q, mcnt_d;
    logic          req_rd_q, req_rd_d;
    logic          req_wr_q, req_wr_d;
    logic          berr_q, berr_d;
    logic          timeout;
    logic          wait_inc;
    logic          active;
    logic          final_m;
    logic          at_stb;
    logic          at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_HOLD;
            m_q      <= '0;
            t_q      <= '0;
            mcnt_q   <= MW'(1);
            req_rd_q <= 1'b0;
            req_wr_q <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            t_q      <= t_d;
            mcnt_q   <= mcnt_d;
            req_rd_q <= req_rd_d;
            req_wr_q <= req_wr_d;
            berr_q   <= berr_d;
        end
    end

    assign active  = (state_q == ST_RUN) || (state_q == ST_WAIT);
    assign final_m = (m_q == mcnt_q - MW'(1));
    assign at_stb  = (t_q == T_STB);
    assign at_last = (t_q == T_LAST);

    assign m_cycle   = m_q;
    assign t_cycle   = t_q;
    assign m1t1      = (state_q == ST_RUN) && (m_q == '0) && (t_q == '0);
    assign last_m    = active && final_m;
    assign writeback = (state_q == ST_RUN) && at_last;
    // Final M-cycle overlaps the next opcode fetch; requests are ignored there.
    assign fetch_en  = at_stb && ((state_q == ST_HOLD) || (active && final_m));
    assign rd        = fetch_en
                     || (active && !final_m && at_stb && req_rd_q && !req_wr_q);
    assign wr        = active && !final_m && at_stb && req_wr_q;
    assign stall     = (state_q == ST_WAIT);
    assign halted    = (state_q == ST_HALT);
    assign bus_err   = berr_q;

    assign wait_inc = (state_q == ST_WAIT) && !mem_ready && !timeout;

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        t_d      = t_q;
        mcnt_d   = mcnt_q;
        req_rd_d = req_rd_q;
        req_wr_d = req_wr_q;
        berr_d   = berr_q;
        if (m1t1) mcnt_d = MW'(sat_count(int'(m_count), MAX_M));
        unique case (state_q)
            ST_HOLD: begin
                if (at_last) begin
                    state_d = ST_RUN;
                    t_d     = '0;
                    m_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (t_q == '0) begin
                    req_rd_d = mem_req_rd;
                    req_wr_d = mem_req_wr;
                end
                if (at_stb && (rd || wr) && !mem_ready) begin
                    state_d = ST_WAIT;
                end else if (at_last) begin
                    t_d = '0;
                    if (final_m) begin
                        m_d = '0;
                        if (halt_req) state_d = ST_HALT;
                    end else begin
                        m_d = m_q + 1'b1;
                    end
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (mem_ready || timeout) begin
                    state_d = ST_RUN;
                    t_d     = t_q + 1'b1;
                    if (!mem_ready) berr_d = 1'b1;
                end
            end
            ST_HALT: begin
                m_d = '0;
                t_d = '0;
                if (wake) state_d = ST_RUN;
            end
            default: state_d = ST_HOLD;
        endcase
    end

    mcycle_wait_ctr #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_ctr (
        .clk_i     (clk),
        .rst_i     (rst),
        .inc_i     (wait_inc),
        .timeout_o (timeout)
    );

endmodule
